// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one non-stallable pipelined FP add/sub core
// among NREQ requesters, with credit-protected per-requester response FIFOs.
module fp_add_arbiter #(
    parameter int NREQ      = 4,
    parameter int ADDER_LAT = 4,
    parameter int RSP_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_mode,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [32*NREQ-1:0] rsp_data,
    output logic [31:0]        add_a,
    output logic [31:0]        add_b,
    output logic               add_mode,
    input  logic [31:0]        add_result,
    output logic               busy
);
    localparam int IW   = $clog2(NREQ);
    localparam int CW   = $clog2(RSP_DEPTH + 1);
    localparam int PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int NTAG = ADDER_LAT + 1;

    logic [IW-1:0]   rr_ptr_r;
    logic [CW-1:0]   credit_r [NREQ];
    logic [NTAG-1:0] tag_valid_r;
    logic [IW-1:0]   tag_id_r [NTAG];
    logic [31:0]     mem_r [NREQ][RSP_DEPTH];
    logic [PW-1:0]   rd_ptr_r [NREQ];
    logic [PW-1:0]   wr_ptr_r [NREQ];
    logic [CW-1:0]   count_r [NREQ];

    logic [NREQ-1:0] eligible_s;
    logic [NREQ-1:0] grant_s;
    logic [NREQ-1:0] push_s;
    logic [NREQ-1:0] pop_s;
    logic            found_s;
    logic [IW-1:0]   grant_id_s;
    logic [IW:0]     cand_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(RSP_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // First eligible requester at or after rr_ptr, wrapping; credit-less requesters are skipped.
    always_comb begin
        eligible_s = '0;
        found_s    = 1'b0;
        grant_id_s = '0;
        cand_s     = '0;
        grant_s    = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible_s[i] = req_valid[i] && (credit_r[i] != '0);
        end
        for (int k = 0; k < NREQ; k++) begin
            cand_s = {1'b0, rr_ptr_r} + (IW+1)'(k);
            if (cand_s >= (IW+1)'(NREQ)) begin
                cand_s = cand_s - (IW+1)'(NREQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && eligible_s[cand_s[IW-1:0]]) begin
                found_s    = 1'b1;
                grant_id_s = cand_s[IW-1:0];
            end else begin
                found_s = found_s;
            end
        end
        if (found_s && !reset) begin
            grant_s[grant_id_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    assign req_ready = grant_s;

    // Operand registers feeding the core and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r <= '0;
            add_a    <= 32'h0;
            add_b    <= 32'h0;
            add_mode <= 1'b0;
        end else if (found_s) begin
            rr_ptr_r <= (grant_id_s == IW'(NREQ - 1)) ? '0 : grant_id_s + IW'(1);
            add_a    <= req_a[32*grant_id_s +: 32];
            add_b    <= req_b[32*grant_id_s +: 32];
            add_mode <= req_mode[grant_id_s];
        end
    end

    // Credits: a grant and a pop in the same cycle cancel out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (reset) begin
                credit_r[i] <= CW'(RSP_DEPTH);
            end else if (grant_s[i] && !pop_s[i]) begin
                credit_r[i] <= credit_r[i] - CW'(1);
            end else if (!grant_s[i] && pop_s[i]) begin
                credit_r[i] <= credit_r[i] + CW'(1);
            end
        end
    end

    // Tag pipeline; the last stage lines up with add_result.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid_r <= '0;
            for (int s = 0; s < NTAG; s++) begin
                tag_id_r[s] <= '0;
            end
        end else begin
            tag_valid_r <= {tag_valid_r[NTAG-2:0], found_s};
            tag_id_r[0] <= grant_id_s;
            for (int s = 1; s < NTAG; s++) begin
                tag_id_r[s] <= tag_id_r[s-1];
            end
        end
    end

    // FIFO status, head data, push/pop decode and busy.
    always_comb begin
        push_s    = '0;
        pop_s     = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            push_s[i]             = tag_valid_r[NTAG-1] && (tag_id_r[NTAG-1] == IW'(i));
            rsp_valid[i]          = (count_r[i] != '0);
            pop_s[i]              = rsp_valid[i] && rsp_ready[i];
            rsp_data[32*i +: 32]  = rsp_valid[i] ? mem_r[i][rd_ptr_r[i]] : 32'h0;
        end
        busy = (|tag_valid_r) || (|rsp_valid);
    end

    // Per-requester response FIFOs; contents are discarded on reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (reset) begin
                rd_ptr_r[i] <= '0;
                wr_ptr_r[i] <= '0;
                count_r[i]  <= '0;
            end else begin
                if (push_s[i]) begin
                    mem_r[i][wr_ptr_r[i]] <= add_result;
                    wr_ptr_r[i]           <= ptr_inc(wr_ptr_r[i]);
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= ptr_inc(rd_ptr_r[i]);
                end
                if (push_s[i] && !pop_s[i]) begin
                    count_r[i] <= count_r[i] + CW'(1);
                end else if (!push_s[i] && pop_s[i]) begin
                    count_r[i] <= count_r[i] - CW'(1);
                end
            end
        end
    end

endmodule
